// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the word-oriented UART transmitter:
//   - frame geometry (data bits per byte, bytes per word)
//   - FSM state encoding (3-bit)
//   - next_enabled(): first byte index at or above a start index whose
//     group is not disabled, or IDX_END when there is none.
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_BYTES     = 4;

   // idx value meaning "no more bytes in this word"
   localparam logic [2:0] IDX_END = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Scan downwards so the lowest qualifying index is the one that sticks.
   function automatic logic [2:0] next_enabled(input logic [3:0] disabled,
                                               input logic [2:0] from_idx);
      logic [2:0] result;
      result = IDX_END;
      for (int i = UART_BYTES - 1; i >= 0; i--) begin
         if ((3'(i) >= from_idx) && !disabled[i]) begin
            result = 3'(i);
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_byte_shifter.sv
// ---------------------------------------------------------------------------
// uart_byte_shifter
//   8-bit LSB-first shift register with its 3-bit bit counter.
//   Ports:
//     clock, reset  system clock, async active-high reset
//     load          capture load_data, bit counter -> 0
//     shift         move to the next data bit, bit counter + 1
//     load_data     byte to serialise
//     first_bit     bit currently at the output end (d0 right after load)
//     next_bit      bit that becomes current after the next shift
//     last_bit      the current bit is d7
// ---------------------------------------------------------------------------
module uart_byte_shifter
   import uart_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic                      shift,
   input  logic [UART_DATA_BITS-1:0] load_data,
   output logic                      first_bit,
   output logic                      next_bit,
   output logic                      last_bit
);

   logic [UART_DATA_BITS-1:0] shift_r;
   logic [2:0]                bit_cnt_r;

   // Shift register and bit counter: load wins over shift.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_r   <= {UART_DATA_BITS{1'b0}};
         bit_cnt_r <= 3'd0;
      end else if (load) begin
         shift_r   <= load_data;
         bit_cnt_r <= 3'd0;
      end else if (shift) begin
         shift_r   <= {1'b0, shift_r[UART_DATA_BITS-1:1]};
         bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
         shift_r   <= shift_r;
         bit_cnt_r <= bit_cnt_r;
      end
   end

   assign first_bit = shift_r[0];
   assign next_bit  = shift_r[1];
   assign last_bit  = (bit_cnt_r == 3'd7);

endmodule

// File: rtl/uart_word_tx.sv
// ---------------------------------------------------------------------------
// uart_word_tx
//   8N1 UART transmitter that sends a 32-bit word as up to four bytes,
//   least-significant byte first, skipping byte groups flagged as disabled.
//   Bit timing comes from the shared prescaler strobe on trx_tick: a bit
//   ends on the BITLENGTH-th tick seen after the cycle in which it began.
//   Parameters:
//     BITLENGTH        trx_tick strobes per serial bit (>= 2)
//   Ports:
//     clock            system clock
//     reset            asynchronous, active-high reset
//     trx_tick         one-cycle timing strobe
//     data             word to send (latched on acceptance)
//     disabled_groups  bit i set: skip byte i (latched on acceptance)
//     write            send request, honoured only while busy is low
//     busy             high while a word is in flight
//     tx               serial line, idle high, registered
// ---------------------------------------------------------------------------
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int BITLENGTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        trx_tick,
   input  logic [31:0] data,
   input  logic [3:0]  disabled_groups,
   input  logic        write,
   output logic        busy,
   output logic        tx
);

   localparam int                TICK_W    = $clog2(BITLENGTH);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BITLENGTH - 1);

   uart_state_t       state_r;
   logic [TICK_W-1:0] tick_cnt_r;
   logic [2:0]        idx_r;
   logic [31:0]       data_r;
   logic [3:0]        groups_r;
   logic              busy_r;
   logic              tx_r;

   logic              accept_s;
   logic              in_bit_s;
   logic              bit_end_s;
   logic [2:0]        sel_idx_s;
   logic              found_s;
   logic              load_s;
   logic              shift_s;
   logic [7:0]        sel_byte_s;
   logic              first_bit_s;
   logic              next_bit_s;
   logic              last_bit_s;

   // Control decode: acceptance, bit-boundary detection and byte selection.
   always_comb begin
      accept_s  = write & ~busy_r;
      // Ticks only matter while a serial bit is on the line.
      in_bit_s  = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP);
      bit_end_s = in_bit_s && trx_tick && (tick_cnt_r == TICK_LAST);
      sel_idx_s = next_enabled(groups_r, idx_r);
      found_s   = (sel_idx_s != IDX_END);
      load_s    = (state_r == ST_SELECT) && found_s;
      shift_s   = (state_r == ST_DATA) && bit_end_s;
   end

   // Byte lane multiplexer for the selected byte index.
   always_comb begin
      case (sel_idx_s)
         3'd0:    sel_byte_s = data_r[7:0];
         3'd1:    sel_byte_s = data_r[15:8];
         3'd2:    sel_byte_s = data_r[23:16];
         3'd3:    sel_byte_s = data_r[31:24];
         default: sel_byte_s = 8'h00;
      endcase
   end

   uart_byte_shifter u_shifter (
      .clock     (clock),
      .reset     (reset),
      .load      (load_s),
      .shift     (shift_s),
      .load_data (sel_byte_s),
      .first_bit (first_bit_s),
      .next_bit  (next_bit_s),
      .last_bit  (last_bit_s)
   );

   // Tick counter: counts ticks within the current bit and wraps at the
   // boundary, so the tick ending one bit never counts toward the next.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt_r <= {TICK_W{1'b0}};
      end else if (!in_bit_s) begin
         tick_cnt_r <= {TICK_W{1'b0}};
      end else if (trx_tick) begin
         if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= {TICK_W{1'b0}};
         end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
         end
      end else begin
         tick_cnt_r <= tick_cnt_r;
      end
   end

   // Word/frame sequencer with registered tx and busy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         idx_r    <= 3'd0;
         data_r   <= 32'h0000_0000;
         groups_r <= 4'h0;
         busy_r   <= 1'b0;
         tx_r     <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               tx_r <= 1'b1;
               if (accept_s) begin
                  data_r   <= data;
                  groups_r <= disabled_groups;
                  idx_r    <= 3'd0;
                  busy_r   <= 1'b1;
                  state_r  <= ST_SELECT;
               end else begin
                  // busy is released one cycle after returning here, so a
                  // word always keeps busy high through one idle cycle.
                  idx_r  <= 3'd0;
                  busy_r <= 1'b0;
               end
            end

            ST_SELECT: begin
               if (found_s) begin
                  idx_r   <= sel_idx_s;
                  tx_r    <= 1'b0;
                  state_r <= ST_START;
               end else begin
                  idx_r   <= IDX_END;
                  tx_r    <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end

            ST_START: begin
               if (bit_end_s) begin
                  tx_r    <= first_bit_s;
                  state_r <= ST_DATA;
               end else begin
                  tx_r    <= 1'b0;
               end
            end

            ST_DATA: begin
               if (bit_end_s) begin
                  if (last_bit_s) begin
                     tx_r    <= 1'b1;
                     state_r <= ST_STOP;
                  end else begin
                     // The shifter advances on this same edge, so the
                     // pre-shift next_bit is the bit that goes out now.
                     tx_r <= next_bit_s;
                  end
               end else begin
                  tx_r <= tx_r;
               end
            end

            ST_STOP: begin
               tx_r <= 1'b1;
               if (bit_end_s) begin
                  idx_r   <= idx_r + 3'd1;
                  state_r <= ST_SELECT;
               end else begin
                  idx_r   <= idx_r;
               end
            end

            default: begin
               state_r <= ST_IDLE;
               idx_r   <= 3'd0;
               busy_r  <= 1'b0;
               tx_r    <= 1'b1;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign tx   = tx_r;

endmodule

// File: tb/tb_uart_word_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_word_tx
//   Scoreboard bench: each issued word (data, disabled groups) is queued;
//   a monitor pops it when busy rises and follows the serial line, deriving
//   the expected frames (enabled bytes, LSB first, 8N1) and the bit
//   boundaries by counting the ticks it sees itself.
// ---------------------------------------------------------------------------
module tb_uart_word_tx;

   localparam int BL = 4;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  g;
   } word_t;

   logic        clock;
   logic        reset;
   logic        trx_tick;
   logic [31:0] data;
   logic [3:0]  disabled_groups;
   logic        write;
   logic        busy;
   logic        tx;

   int    vectors     = 0;
   int    miscompares = 0;
   word_t exp_q[$];
   int    tick_period = 1;   // 0: random ticks, N: one tick every N cycles
   bit    scramble    = 1'b0;
   bit    mon_active  = 1'b0;

   uart_word_tx #(.BITLENGTH(BL)) dut (
      .clock           (clock),
      .reset           (reset),
      .trx_tick        (trx_tick),
      .data            (data),
      .disabled_groups (disabled_groups),
      .write           (write),
      .busy            (busy),
      .tx              (tx)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Tick generator, driven on the falling edge.
   initial begin : tick_gen
      int phase;
      phase    = 0;
      trx_tick = 1'b0;
      forever begin
         @(negedge clock);
         if (tick_period == 0) begin
            trx_tick = ($urandom_range(1, 0) == 1);
         end else begin
            phase    = (phase + 1) % tick_period;
            trx_tick = (phase == 0);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Follow one word on the line; entered at the falling edge where busy
   // is first seen high (the byte-selection cycle).
   task automatic check_word(input logic [31:0] d, input logic [3:0] g);
      logic [9:0] frame;
      int ticks;
      int guard;
      check("select_tx", tx, 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (!g[i]) begin
            frame = {1'b1, d[8*i +: 8], 1'b0};
            @(posedge clock);   // frame starts; a tick here is not counted
            for (int k = 0; k < 10; k++) begin
               ticks = 0;
               guard = 0;
               while (ticks < BL && guard < 200) begin
                  @(negedge clock);
                  if (reset) return;
                  check($sformatf("tx byte%0d bit%0d", i, k), tx, {31'd0, frame[k]});
                  check("busy_in_frame", busy, 32'd1);
                  @(posedge clock);
                  if (trx_tick) ticks++;
                  guard++;
               end
               if (ticks < BL) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL bit_timeout: byte %0d bit %0d saw %0d ticks, expected %0d", i, k, ticks, BL);
                  return;
               end
            end
            @(negedge clock);
            if (reset) return;
            check("gap_tx", tx, 32'd1);
            check("gap_busy", busy, 32'd1);
         end
      end
      @(posedge clock);
      @(negedge clock);
      if (reset) return;
      check("tail_busy", busy, 32'd1);
      check("tail_tx", tx, 32'd1);
      @(posedge clock);
      @(negedge clock);
      if (reset) return;
      check("busy_release", busy, 32'd0);
      check("release_tx", tx, 32'd1);
   endtask

   // Monitor: pops the expected word whenever busy rises.
   initial begin : monitor
      logic  prev_busy;
      word_t w;
      prev_busy = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_busy = 1'b0;
         end else if (busy && !prev_busy) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_word: busy rose with nothing outstanding (t=%0t)", $time);
            end else begin
               w          = exp_q.pop_front();
               mon_active = 1'b1;
               check_word(w.d, w.g);
               mon_active = 1'b0;
            end
            prev_busy = busy;
         end else begin
            if (!busy) check("idle_tx", tx, 32'd1);
            prev_busy = busy;
         end
      end
   end

   task automatic idle_cycle();
      @(negedge clock);
      if (scramble) begin
         data            = $urandom;
         disabled_groups = 4'($urandom);
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic [3:0] g);
      int    guard;
      word_t w;
      guard = 0;
      idle_cycle();
      while (busy && guard < 5000) begin
         idle_cycle();
         guard++;
      end
      vectors++;
      if (busy) begin
         miscompares++;
         $display("FAIL send_timeout: busy still %0b after %0d cycles", busy, guard);
      end
      data            = d;
      disabled_groups = g;
      write           = 1'b1;
      w.d = d;
      w.g = g;
      exp_q.push_back(w);
      @(negedge clock);
      write = 1'b0;
      if (scramble) begin
         data            = $urandom;
         disabled_groups = 4'($urandom);
      end
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || mon_active || busy) && guard < 20000) begin
         idle_cycle();
         guard++;
      end
      vectors++;
      if (guard >= 20000) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d words outstanding, busy %0b", exp_q.size(), busy);
      end
   endtask

   initial begin : stimulus
      int    busy_cycles;
      word_t w;
      reset           = 1'b1;
      write           = 1'b0;
      data            = 32'h0000_0000;
      disabled_groups = 4'h0;
      repeat (3) @(negedge clock);
      check("reset_tx", tx, 32'd1);
      check("reset_busy", busy, 32'd0);
      reset = 1'b0;

      // single byte 0xA5
      send_word(32'h0000_00A5, 4'b1110);
      wait_done();

      // four bytes in order
      send_word(32'h4433_2211, 4'b0000);
      wait_done();

      // all groups disabled; a held write during busy must be ignored
      @(negedge clock);
      data            = 32'hDEAD_BEEF;
      disabled_groups = 4'b1111;
      write           = 1'b1;
      w.d = 32'hDEAD_BEEF;
      w.g = 4'b1111;
      exp_q.push_back(w);
      @(negedge clock);
      busy_cycles     = busy ? 1 : 0;
      data            = 32'h1234_5678;
      disabled_groups = 4'b0000;
      @(negedge clock);
      busy_cycles += busy ? 1 : 0;
      @(negedge clock);
      busy_cycles += busy ? 1 : 0;
      write = 1'b0;
      @(negedge clock);
      busy_cycles += busy ? 1 : 0;
      check("all_disabled_busy_cycles", busy_cycles, 32'd2);
      wait_done();

      // slow ticks, one byte 0xFF
      tick_period = 3;
      send_word(32'h0000_00FF, 4'b1110);
      wait_done();
      tick_period = 1;

      // reset during d3 of byte 1
      send_word($urandom, 4'b0000);
      repeat (58) @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      check("midframe_reset_tx", tx, 32'd1);
      check("midframe_reset_busy", busy, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      send_word(32'h0000_5A3C, 4'b1100);
      wait_done();

      // inputs change every cycle after acceptance
      scramble = 1'b1;
      for (int n = 0; n < 3; n++) begin
         send_word($urandom, 4'($urandom_range(14, 0)));
      end
      wait_done();
      scramble = 1'b0;

      // random words under random tick patterns
      for (int n = 0; n < 10; n++) begin
         tick_period = int'($urandom_range(3, 0));
         send_word($urandom, 4'($urandom_range(15, 0)));
      end
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
